// File: rtl/priority_arbiter_rr.sv
// Registered one-hot request arbiter with fixed or round-robin priority.
// A grant is held until the shared resource acknowledges it.
module priority_arbiter_rr #(
    parameter  int WIDTH = 8,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rr_mode,
    input  logic [WIDTH-1:0] req,
    input  logic             ack,
    output logic [WIDTH-1:0] grant,
    output logic [IDXW-1:0]  grant_idx,
    output logic             grant_valid,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [IDXW:0]   WLIM = (IDXW+1)'(WIDTH);
    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH-1);

    state_t             state;
    state_t             state_nx;
    logic [IDXW-1:0]    ptr;
    logic [IDXW-1:0]    ptr_nx;
    logic [IDXW-1:0]    start;
    logic [IDXW-1:0]    win_idx;
    logic [IDXW-1:0]    idx_q;
    logic [WIDTH-1:0]   grant_q;
    logic [WIDTH-1:0]   rot;
    logic [2*WIDTH-1:0] dbl;
    logic [IDXW:0]      sum;
    logic               mode_q;
    logic               found;

    // Rotate so the scan always starts at bit 0, then map the hit back.
    always_comb begin
        start = rr_mode ? ptr : '0;
        dbl   = {req, req} >> start;
        rot   = dbl[WIDTH-1:0];
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, start} + (IDXW+1)'(i);
            end
        end
        if (sum >= WLIM) begin
            sum = sum - WLIM;
        end
        win_idx = sum[IDXW-1:0];
    end

    assign ptr_nx = (idx_q == LAST) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == GRANT) begin
                grant_q <= WIDTH'(1) << win_idx;
                idx_q   <= win_idx;
                mode_q  <= rr_mode;
            end else if (state == GRANT && ack) begin
                grant_q <= '0;
                idx_q   <= '0;
                if (mode_q) begin
                    ptr <= ptr_nx;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (en && |req) begin
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        grant       = grant_q;
        grant_idx   = idx_q;
        grant_valid = (state == GRANT);
        busy        = (state == GRANT);
    end

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed-vector bench for priority_arbiter_rr (WIDTH=8).
// Inputs change between edges; outputs are checked 1ns after each edge.
module tb_priority_arbiter_rr;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rr_mode;
    logic [7:0] req;
    logic       ack;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       busy;

    int n_chk;
    int n_fail;

    typedef struct {
        logic       en;
        logic       rr;
        logic [7:0] req;
        logic       ack;
        logic [7:0] eg;
        logic [2:0] ei;
        logic       ev;
        string      name;
    } vec_t;

    vec_t vecs[$];

    priority_arbiter_rr #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .rr_mode(rr_mode),
        .req(req),
        .ack(ack),
        .grant(grant),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] eg,
                         input logic [2:0] ei, input logic ev);
        n_chk++;
        if (grant !== eg || grant_idx !== ei || grant_valid !== ev ||
            busy !== ev) begin
            n_fail++;
            $display("FAIL %s: got grant=%h idx=%0d valid=%b busy=%b, want grant=%h idx=%0d valid=%b",
                     name, grant, grant_idx, grant_valid, busy, eg, ei, ev);
        end
    endtask

    task automatic add(input string name, input logic e, input logic r,
                       input logic [7:0] q, input logic a, input logic [7:0] eg,
                       input logic [2:0] ei, input logic ev);
        vec_t v;
        v.en   = e;
        v.rr   = r;
        v.req  = q;
        v.ack  = a;
        v.eg   = eg;
        v.ei   = ei;
        v.ev   = ev;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        en      = 1'b0;
        rr_mode = 1'b0;
        req     = 8'h00;
        ack     = 1'b0;

        // Fixed priority grant and hold, inputs wiggled while held.
        add("fix_grant",  1, 0, 8'h3A, 0, 8'h02, 3'd1, 1);
        add("fix_hold1",  1, 0, 8'h3A, 0, 8'h02, 3'd1, 1);
        add("fix_hold2",  0, 0, 8'h3A, 0, 8'h02, 3'd1, 1);
        add("fix_hold3",  1, 1, 8'h80, 0, 8'h02, 3'd1, 1);
        add("fix_hold4",  1, 0, 8'h00, 0, 8'h02, 3'd1, 1);
        add("fix_hold5",  1, 0, 8'h3A, 0, 8'h02, 3'd1, 1);
        add("fix_ack",    1, 0, 8'h3A, 1, 8'h00, 3'd0, 0);
        for (int i = 0; i < 10; i++)
            add("empty_req", 1, 0, 8'h00, 0, 8'h00, 3'd0, 0);
        add("en_low",     0, 0, 8'h61, 0, 8'h00, 3'd0, 0);
        add("en_low2",    0, 1, 8'h61, 0, 8'h00, 3'd0, 0);
        add("fix_61",     1, 0, 8'h61, 0, 8'h01, 3'd0, 1);
        add("fix_61_ack", 1, 0, 8'h61, 1, 8'h00, 3'd0, 0);
        add("spur_ack",   1, 0, 8'h00, 1, 8'h00, 3'd0, 0);
        add("spur_ack2",  1, 1, 8'h00, 1, 8'h00, 3'd0, 0);
        // Round-robin sweep from ptr=0 over a full request vector.
        for (int k = 0; k < 9; k++) begin
            add("rr_rot", 1, 1, 8'hFF, 0, 8'h01 << (k % 8), 3'(k % 8), 1);
            add("rr_rot_ack", 1, 1, 8'hFF, 1, 8'h00, 3'd0, 0);
        end
        // ptr=1 now; grant idx 6 to leave ptr=7, then wrap.
        add("rr_b6",      1, 1, 8'h40, 0, 8'h40, 3'd6, 1);
        add("rr_b6_ack",  1, 1, 8'h40, 1, 8'h00, 3'd0, 0);
        add("rr_wrap",    1, 1, 8'h41, 0, 8'h01, 3'd0, 1);
        add("rr_wrap_ack",1, 1, 8'h41, 1, 8'h00, 3'd0, 0);
        add("rr_p1",      1, 1, 8'h41, 0, 8'h40, 3'd6, 1);
        add("rr_p1_ack",  1, 1, 8'h41, 1, 8'h00, 3'd0, 0);
        // ptr=7: fixed grant, mode toggled while held must not move ptr.
        add("mode_fix",   1, 0, 8'h06, 0, 8'h02, 3'd1, 1);
        add("mode_tog",   1, 1, 8'h06, 0, 8'h02, 3'd1, 1);
        add("mode_ack",   1, 1, 8'h06, 1, 8'h00, 3'd0, 0);
        add("mode_rr",    1, 1, 8'h06, 0, 8'h02, 3'd1, 1);
        add("mode_rr_ack",1, 1, 8'h06, 1, 8'h00, 3'd0, 0);
        // ptr=2: single requester wins regardless of pointer.
        add("single_b5",  1, 1, 8'h20, 0, 8'h20, 3'd5, 1);

        #12;
        check("reset_state", 8'h00, 3'd0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            en      = vecs[i].en;
            rr_mode = vecs[i].rr;
            req     = vecs[i].req;
            ack     = vecs[i].ack;
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].eg, vecs[i].ei, vecs[i].ev);
        end

        // Requester drops while held; then async reset between edges.
        req = 8'h00;
        ack = 1'b0;
        @(posedge clk);
        #1;
        check("drop_req_hold", 8'h20, 3'd5, 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", 8'h00, 3'd0, 0);
        #2;
        rst = 1'b0;
        en      = 1'b1;
        rr_mode = 1'b1;
        req     = 8'hFF;
        @(posedge clk);
        #1;
        check("post_rst_ptr0", 8'h01, 3'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
